// File: rtl/mem_req_arbiter.sv
// Two-requester (instruction fetch / data access) arbiter in front of the AXI memory wrapper.
// Optional macro ARB_ROUND_ROBIN_EN swaps fixed data priority + starvation limit for round robin.
module mem_req_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              cpu_clk,
    input  logic              cpu_reset,
    input  logic              inst_req_valid,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_req_ready,
    output logic [31:0]       inst_rdata,
    output logic              inst_rdata_valid,
    input  logic              inst_rdata_ready,
    input  logic              data_memread,
    input  logic              data_memwrite,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_wstrb,
    output logic              data_req_ready,
    output logic [31:0]       data_rdata,
    output logic              data_rdata_valid,
    input  logic              data_rdata_ready,
    output logic [ADDR_W-1:0] Address,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [31:0]       Write_data,
    output logic [3:0]        Write_strb,
    input  logic              Mem_Req_Ready,
    input  logic [31:0]       Read_data,
    input  logic              Read_data_Valid,
    output logic              Read_data_Ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    logic [1:0] r_state;
    logic       r_owner;

    logic w_instPend;
    logic w_dataPend;
    logic w_dataWins;
    logic w_canGrant;
    logic w_grantInst;
    logic w_grantData;
    logic w_respInst;
    logic w_respData;

    assign w_instPend = inst_req_valid;
    assign w_dataPend = data_memread | data_memwrite;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_lastGrant;

    assign w_dataWins = w_dataPend & (~w_instPend | (r_lastGrant == OWN_INST));

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset)
            r_lastGrant <= OWN_INST;
        else if (w_grantData)
            r_lastGrant <= OWN_DATA;
        else if (w_grantInst)
            r_lastGrant <= OWN_INST;
    end
`else
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starveCnt;
    logic             w_instForced;

    // Inst has sat through STARVE_LIMIT data grants in a row: it takes the next slot.
    assign w_instForced = (STARVE_LIMIT != 0) && (r_starveCnt == CNT_MAX);
    assign w_dataWins   = w_dataPend & ~(w_instPend & w_instForced);

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset)
            r_starveCnt <= '0;
        else if (w_grantData && w_instPend) begin
            if (r_starveCnt != CNT_MAX)
                r_starveCnt <= r_starveCnt + 1'b1;
        end else if (w_grantData || w_grantInst)
            r_starveCnt <= '0;
    end
`endif

    // Grants are gated by reset so ready outputs drop the instant reset rises.
    assign w_canGrant  = (r_state == S_IDLE) & ~cpu_reset;
    assign w_grantData = w_canGrant & w_dataWins;
    assign w_grantInst = w_canGrant & w_instPend & ~w_dataWins;

    assign inst_req_ready = w_grantInst;
    assign data_req_ready = w_grantData;

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            r_state    <= S_IDLE;
            r_owner    <= OWN_INST;
            Address    <= '0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            Write_data <= '0;
            Write_strb <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grantData) begin
                        Address    <= data_addr;
                        MemWrite   <= data_memwrite;
                        MemRead    <= ~data_memwrite;
                        Write_data <= data_wdata;
                        Write_strb <= data_wstrb;
                        r_owner    <= OWN_DATA;
                        r_state    <= S_REQ;
                    end else if (w_grantInst) begin
                        Address    <= inst_addr;
                        MemWrite   <= 1'b0;
                        MemRead    <= 1'b1;
                        Write_data <= '0;
                        Write_strb <= '0;
                        r_owner    <= OWN_INST;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A write is finished once accepted; a read still owes its data beat.
                    if (Mem_Req_Ready) begin
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        r_state  <= MemWrite ? S_IDLE : S_RESP;
                    end
                end
                S_RESP: begin
                    if (Read_data_Valid && Read_data_Ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_respInst = (r_state == S_RESP) && (r_owner == OWN_INST);
    assign w_respData = (r_state == S_RESP) && (r_owner == OWN_DATA);

    assign inst_rdata       = w_respInst ? Read_data : 32'h0;
    assign inst_rdata_valid = w_respInst & Read_data_Valid;
    assign data_rdata       = w_respData ? Read_data : 32'h0;
    assign data_rdata_valid = w_respData & Read_data_Valid;
    assign Read_data_Ready  = (w_respInst & inst_rdata_ready) | (w_respData & data_rdata_ready);

endmodule
